// File: rtl/mapa_pkg.sv
// mapa_pkg
//   Shared constants for the map RAM arbiter: coordinate and cell widths,
//   the empty-cell value and the arbiter state encodings.
//   Used by mapa_rr_pick and mapa_arbiter.
package mapa_pkg;

    localparam int COORD_W = 5;
    localparam int CELL_W  = 4;

    localparam logic [CELL_W-1:0] CELL_VAZIO = 4'd0;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_CLEAR  = 2'd0;
    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd1;
    localparam logic [STATE_W-1:0] ST_ACCESS = 2'd2;
    localparam logic [STATE_W-1:0] ST_RESP   = 2'd3;

    // Width of a requester index; at least one bit so a single port still works.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mapa_rr_pick.sv
// mapa_rr_pick
//   Combinational round-robin picker. Searches the request vector starting
//   one past the last granted port and wrapping around; the first set bit wins.
//   Ports:
//     req_i     request vector, one bit per port
//     last_i    index of the most recently granted port
//     valid_o   at least one request present
//     winner_o  index of the selected port (0 when valid_o is low)
module mapa_rr_pick
    import mapa_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   winner_o
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        idx      = '0;
        // Offset NUM_REQ lands back on last_i itself, so a lone requester
        // that was just served is still found.
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = IDX_W'((32'(last_i) + off) % NUM_REQ);
            if (!valid_o && req_i[idx]) begin
                valid_o  = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/mapa_arbiter.sv
// mapa_arbiter
//   Sequences every access to the single-port map RAM and shares it
//   round-robin between the update engine (port 0), the food spawner
//   (port 1) and the video renderer (port 2). One access every 3 cycles:
//   grant in IDLE, registered strobe in ACCESS, ack plus read data in RESP.
//   Optional feature macro: MAPA_CLEAR_EN -- after reset, write CELL_VAZIO
//   to every cell (row-major) before any requester is served.
//   Ports:
//     clk, reset        clock; asynchronous active-high reset
//     req, we           per-port request / write-enable, held until ack
//     req_x, req_y      per-port coordinates, 5 bits per port
//     req_dado          per-port write data, 4 bits per port
//     ack               one-cycle completion pulse per port
//     rdata             read data, valid while an ack bit is high
//     pronto            map usable; requests served only while high
//     mapa_x, mapa_y    RAM address (registered)
//     mapa_read/write   RAM strobes (registered)
//     mapa_dado_write   RAM write data (registered)
//     mapa_dado_read    RAM read data, valid the cycle after mapa_read
module mapa_arbiter
    import mapa_pkg::*;
#(
    parameter int unsigned MAPA_WIDTH  = 20,
    parameter int unsigned MAPA_HEIGHT = 15,
    parameter int unsigned NUM_REQ     = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         we,
    input  logic [COORD_W*NUM_REQ-1:0] req_x,
    input  logic [COORD_W*NUM_REQ-1:0] req_y,
    input  logic [CELL_W*NUM_REQ-1:0]  req_dado,
    output logic [NUM_REQ-1:0]         ack,
    output logic [CELL_W-1:0]          rdata,
    output logic                       pronto,
    output logic [COORD_W-1:0]         mapa_x,
    output logic [COORD_W-1:0]         mapa_y,
    output logic                       mapa_read,
    output logic                       mapa_write,
    output logic [CELL_W-1:0]          mapa_dado_write,
    input  logic [CELL_W-1:0]          mapa_dado_read
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

`ifdef MAPA_CLEAR_EN
    localparam logic [STATE_W-1:0] ST_RESET = ST_CLEAR;
`else
    localparam logic [STATE_W-1:0] ST_RESET = ST_IDLE;
`endif

    logic [STATE_W-1:0] state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic               rd_ok_q, rd_ok_d;
    logic               pronto_q, pronto_d;
    logic [COORD_W-1:0] addr_x_q, addr_x_d;
    logic [COORD_W-1:0] addr_y_q, addr_y_d;
    logic [CELL_W-1:0]  dado_q, dado_d;
    logic               read_q, read_d;
    logic               write_q, write_d;
`ifdef MAPA_CLEAR_EN
    logic [COORD_W-1:0] clr_x_q, clr_x_d;
    logic [COORD_W-1:0] clr_y_q, clr_y_d;
`endif

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [COORD_W-1:0] sel_x, sel_y;
    logic [CELL_W-1:0]  sel_dado;
    logic               sel_we;
    logic               sel_in_range;

    mapa_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i    (req),
        .last_i   (last_q),
        .valid_o  (pick_valid),
        .winner_o (pick_idx)
    );

    // Operand mux for the port the picker selected.
    always_comb begin
        sel_x    = '0;
        sel_y    = '0;
        sel_dado = '0;
        sel_we   = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == pick_idx) begin
                sel_x    = req_x[i*COORD_W +: COORD_W];
                sel_y    = req_y[i*COORD_W +: COORD_W];
                sel_dado = req_dado[i*CELL_W +: CELL_W];
                sel_we   = we[i];
            end
        end
        sel_in_range = (32'(sel_x) < MAPA_WIDTH) && (32'(sel_y) < MAPA_HEIGHT);
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        win_d    = win_q;
        rd_ok_d  = rd_ok_q;
        pronto_d = pronto_q;
        addr_x_d = addr_x_q;
        addr_y_d = addr_y_q;
        dado_d   = dado_q;
        read_d   = 1'b0;
        write_d  = 1'b0;
`ifdef MAPA_CLEAR_EN
        clr_x_d  = clr_x_q;
        clr_y_d  = clr_y_q;
`endif
        case (state_q)
`ifdef MAPA_CLEAR_EN
            ST_CLEAR: begin
                pronto_d = 1'b0;
                write_d  = 1'b1;
                addr_x_d = clr_x_q;
                addr_y_d = clr_y_q;
                dado_d   = CELL_VAZIO;
                if (32'(clr_x_q) == MAPA_WIDTH - 1) begin
                    clr_x_d = '0;
                    if (32'(clr_y_q) == MAPA_HEIGHT - 1) begin
                        clr_y_d  = '0;
                        // Last clear write is issued in the first IDLE cycle,
                        // which is also the first cycle with pronto high.
                        state_d  = ST_IDLE;
                        pronto_d = 1'b1;
                    end else begin
                        clr_y_d = clr_y_q + 1'b1;
                    end
                end else begin
                    clr_x_d = clr_x_q + 1'b1;
                end
            end
`endif
            ST_IDLE: begin
                pronto_d = 1'b1;
                if (pronto_q && pick_valid) begin
                    win_d    = pick_idx;
                    addr_x_d = sel_x;
                    addr_y_d = sel_y;
                    dado_d   = sel_dado;
                    // Out-of-range cells get no strobe; reads then return 0.
                    read_d   = sel_in_range && !sel_we;
                    write_d  = sel_in_range && sel_we;
                    rd_ok_d  = sel_in_range && !sel_we;
                    state_d  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                last_d  = win_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RESET;
            last_q   <= IDX_W'(NUM_REQ - 1);
            win_q    <= '0;
            rd_ok_q  <= 1'b0;
            pronto_q <= 1'b0;
            addr_x_q <= '0;
            addr_y_q <= '0;
            dado_q   <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
`ifdef MAPA_CLEAR_EN
            clr_x_q  <= '0;
            clr_y_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            win_q    <= win_d;
            rd_ok_q  <= rd_ok_d;
            pronto_q <= pronto_d;
            addr_x_q <= addr_x_d;
            addr_y_q <= addr_y_d;
            dado_q   <= dado_d;
            read_q   <= read_d;
            write_q  <= write_d;
`ifdef MAPA_CLEAR_EN
            clr_x_q  <= clr_x_d;
            clr_y_q  <= clr_y_d;
`endif
        end
    end

    // RAM data arrives in the RESP cycle, so it is passed straight through
    // while the ack is up rather than registered a second time.
    always_comb begin
        ack   = '0;
        rdata = CELL_VAZIO;
        if (state_q == ST_RESP) begin
            ack[win_q] = 1'b1;
            if (rd_ok_q) begin
                rdata = mapa_dado_read;
            end
        end
    end

    assign pronto          = pronto_q;
    assign mapa_x          = addr_x_q;
    assign mapa_y          = addr_y_q;
    assign mapa_read       = read_q;
    assign mapa_write      = write_q;
    assign mapa_dado_write = dado_q;

endmodule

// File: tb/tb_mapa_arbiter.sv
// tb_mapa_arbiter
//   Self-checking bench for mapa_arbiter with a behavioural map RAM.
//   Expected acks are queued when requests are driven and popped on ack.
//   Honours MAPA_CLEAR_EN when defined for the build.
module tb_mapa_arbiter;

    localparam int W = 20;
    localparam int H = 15;
    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req, we;
    logic [14:0] req_x, req_y;
    logic [11:0] req_dado;
    logic [2:0]  ack;
    logic [3:0]  rdata;
    logic        pronto;
    logic [4:0]  mapa_x, mapa_y;
    logic        mapa_read, mapa_write;
    logic [3:0]  mapa_dado_write, mapa_dado_read;

    always #5 clk = ~clk;

    mapa_arbiter #(
        .MAPA_WIDTH  (W),
        .MAPA_HEIGHT (H),
        .NUM_REQ     (N)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .we              (we),
        .req_x           (req_x),
        .req_y           (req_y),
        .req_dado        (req_dado),
        .ack             (ack),
        .rdata           (rdata),
        .pronto          (pronto),
        .mapa_x          (mapa_x),
        .mapa_y          (mapa_y),
        .mapa_read       (mapa_read),
        .mapa_write      (mapa_write),
        .mapa_dado_write (mapa_dado_write),
        .mapa_dado_read  (mapa_dado_read)
    );

    // Map RAM model: synchronous write, one-cycle read latency.
    logic [3:0] mem    [0:31][0:31];
    logic [3:0] shadow [0:31][0:31];
    logic [3:0] rd_q = 4'd0;
    int         rd_cnt = 0, wr_cnt = 0;
    logic [4:0] last_wx = '0, last_wy = '0;
    logic [3:0] last_wd = '0;

    always @(posedge clk) begin
        if (mapa_write) begin
            mem[mapa_x][mapa_y] <= mapa_dado_write;
            wr_cnt  <= wr_cnt + 1;
            last_wx <= mapa_x;
            last_wy <= mapa_y;
            last_wd <= mapa_dado_write;
        end
        if (mapa_read) begin
            rd_q   <= mem[mapa_x][mapa_y];
            rd_cnt <= rd_cnt + 1;
        end
    end
    assign mapa_dado_read = rd_q;

    typedef struct {
        int         port;
        bit         rd;
        logic [3:0] data;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic drive_port(input int p, input logic w, input int x, input int y, input logic [3:0] d);
        we[p]            = w;
        req_x[p*5 +: 5]  = 5'(x);
        req_y[p*5 +: 5]  = 5'(y);
        req_dado[p*4 +: 4] = d;
        req[p]           = 1'b1;
    endtask

    task automatic wait_ack(input int bound, output int lat, output logic [2:0] a, output logic [3:0] d);
        lat = -1;
        a   = '0;
        d   = '0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (ack != 3'b000) begin
                lat = i;
                a   = ack;
                d   = rdata;
                break;
            end
        end
    endtask

    task automatic release_all;
        @(posedge clk);
        #1;
        req = '0;
    endtask

    task automatic wait_pronto;
        for (int i = 0; i < 400 && pronto !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (pronto !== 1'b1) begin
            n_fail++;
            $display("FAIL pronto_timeout: got %b expected 1", pronto);
        end
`ifdef MAPA_CLEAR_EN
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                shadow[x][y] = 4'd0;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req   = '0;
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_pronto();
    endtask

    task automatic test_reset;
        req   = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (ack !== 3'b000) begin n_fail++; $display("FAIL reset_ack: got %b expected 000", ack); end
        n_checks++; if (rdata !== 4'd0) begin n_fail++; $display("FAIL reset_rdata: got %0d expected 0", rdata); end
        n_checks++; if (mapa_read !== 1'b0) begin n_fail++; $display("FAIL reset_read: got %b expected 0", mapa_read); end
        n_checks++; if (mapa_write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b expected 0", mapa_write); end
        n_checks++; if (mapa_x !== 5'd0 || mapa_y !== 5'd0) begin n_fail++; $display("FAIL reset_addr: got (%0d,%0d) expected (0,0)", mapa_x, mapa_y); end
        n_checks++; if (mapa_dado_write !== 4'd0) begin n_fail++; $display("FAIL reset_wdata: got %0d expected 0", mapa_dado_write); end
        n_checks++; if (pronto !== 1'b0) begin n_fail++; $display("FAIL reset_pronto: got %b expected 0", pronto); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
`ifdef MAPA_CLEAR_EN
        n_checks++; if (pronto !== 1'b0) begin n_fail++; $display("FAIL pronto_during_clear: got %b expected 0", pronto); end
`else
        n_checks++; if (pronto !== 1'b1) begin n_fail++; $display("FAIL pronto_first_cycle: got %b expected 1", pronto); end
`endif
    endtask

`ifdef MAPA_CLEAR_EN
    task automatic test_clear;
        int cnt, order_err, early_ack, ex, ey, lat;
        logic [2:0] a;
        logic [3:0] d;
        exp_t e;
        cnt = 0; order_err = 0; early_ack = 0; ex = 0; ey = 0;
        req   = '0;
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_port(0, 1'b0, 5, 5, 4'd0);
        sb.push_back('{0, 1'b1, 4'd0});
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ack != 3'b000) early_ack++;
            if (mapa_write) begin
                if (mapa_x !== 5'(ex) || mapa_y !== 5'(ey) || mapa_dado_write !== 4'd0) order_err++;
                cnt++;
                ex++;
                if (ex == W) begin ex = 0; ey++; end
            end
            if (pronto === 1'b1) break;
        end
        n_checks++; if (cnt != W*H) begin n_fail++; $display("FAIL clear_count: got %0d expected %0d", cnt, W*H); end
        n_checks++; if (order_err != 0) begin n_fail++; $display("FAIL clear_order: got %0d bad writes expected 0", order_err); end
        n_checks++; if (early_ack != 0) begin n_fail++; $display("FAIL clear_early_ack: got %0d acks expected 0", early_ack); end
        n_checks++; if (pronto !== 1'b1) begin n_fail++; $display("FAIL clear_pronto: got %b expected 1", pronto); end
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                shadow[x][y] = 4'd0;
        wait_ack(10, lat, a, d);
        e = sb.pop_front();
        n_checks++; if (a !== (3'b001 << e.port) || d !== e.data) begin n_fail++; $display("FAIL clear_held_req: got ack %b data %0d expected ack %b data %0d", a, d, 3'b001 << e.port, e.data); end
        release_all();
    endtask
`endif

    task automatic test_preload;
        int lat;
        logic [2:0] a;
        logic [3:0] d;
        exp_t e;
        do_reset();
        drive_port(0, 1'b0, 5, 5, 4'd0);
        sb.push_back('{0, 1'b1, shadow[5][5]});
        wait_ack(10, lat, a, d);
        e = sb.pop_front();
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL preload_latency: got %0d expected 3", lat); end
        n_checks++; if (a !== (3'b001 << e.port) || d !== e.data) begin n_fail++; $display("FAIL preload_read: got ack %b data %0d expected ack %b data %0d", a, d, 3'b001 << e.port, e.data); end
        release_all();
    endtask

    task automatic test_write_read;
        int lat, rd0, wr0;
        logic [2:0] a;
        logic [3:0] d;
        exp_t e;
        do_reset();
        rd0 = rd_cnt; wr0 = wr_cnt;
        drive_port(0, 1'b1, 3, 4, 4'd7);
        shadow[3][4] = 4'd7;
        sb.push_back('{0, 1'b0, 4'd0});
        wait_ack(10, lat, a, d);
        e = sb.pop_front();
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL write_latency: got %0d expected 3", lat); end
        n_checks++; if (a !== (3'b001 << e.port)) begin n_fail++; $display("FAIL write_ack: got %b expected %b", a, 3'b001 << e.port); end
        n_checks++; if (wr_cnt != wr0 + 1 || rd_cnt != rd0) begin n_fail++; $display("FAIL write_strobes: got wr %0d rd %0d expected wr %0d rd %0d", wr_cnt - wr0, rd_cnt - rd0, 1, 0); end
        n_checks++; if (last_wx !== 5'd3 || last_wy !== 5'd4 || last_wd !== 4'd7) begin n_fail++; $display("FAIL write_addr_data: got (%0d,%0d)=%0d expected (3,4)=7", last_wx, last_wy, last_wd); end
        release_all();
        drive_port(0, 1'b0, 3, 4, 4'd0);
        sb.push_back('{0, 1'b1, shadow[3][4]});
        wait_ack(10, lat, a, d);
        e = sb.pop_front();
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL read_latency: got %0d expected 3", lat); end
        n_checks++; if (a !== (3'b001 << e.port) || d !== e.data) begin n_fail++; $display("FAIL read_back: got ack %b data %0d expected ack %b data %0d", a, d, 3'b001 << e.port, e.data); end
        n_checks++; if (rd_cnt != rd0 + 1) begin n_fail++; $display("FAIL read_strobe: got %0d expected 1", rd_cnt - rd0); end
        release_all();
    endtask

    task automatic test_round_robin;
        int px[3] = '{10, 11, 12};
        int py[3] = '{1, 2, 3};
        int lat, cum, rd0, last;
        logic [2:0] a;
        logic [3:0] d;
        exp_t e;
        do_reset();
        rd0 = rd_cnt;
        for (int p = 0; p < N; p++) drive_port(p, 1'b0, px[p], py[p], 4'd0);
        last = N - 1;
        for (int k = 0; k < 6; k++) begin
            last = (last + 1) % N;
            sb.push_back('{last, 1'b1, shadow[px[last]][py[last]]});
        end
        cum = 0;
        for (int k = 0; k < 6; k++) begin
            wait_ack(12, lat, a, d);
            e = sb.pop_front();
            cum += lat;
            n_checks++; if (a !== (3'b001 << e.port) || d !== e.data) begin n_fail++; $display("FAIL rr_order_%0d: got ack %b data %0d expected ack %b data %0d", k, a, d, 3'b001 << e.port, e.data); end
            n_checks++; if (lat != 3) begin n_fail++; $display("FAIL rr_spacing_%0d: got %0d expected 3", k, lat); end
            if (k == 2) begin
                n_checks++; if (cum > 3*N) begin n_fail++; $display("FAIL rr_max_wait: got %0d expected <= %0d", cum, 3*N); end
            end
        end
        release_all();
        n_checks++; if (rd_cnt != rd0 + 6) begin n_fail++; $display("FAIL rr_read_count: got %0d expected 6", rd_cnt - rd0); end
    endtask

    task automatic test_out_of_range;
        int lat, rd0, wr0;
        logic [2:0] a;
        logic [3:0] d;
        exp_t e;
        do_reset();
        rd0 = rd_cnt;
        drive_port(2, 1'b0, W, 0, 4'd0);
        sb.push_back('{2, 1'b1, 4'd0});
        wait_ack(10, lat, a, d);
        e = sb.pop_front();
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL oor_read_latency: got %0d expected 3", lat); end
        n_checks++; if (a !== (3'b001 << e.port) || d !== e.data) begin n_fail++; $display("FAIL oor_read: got ack %b data %0d expected ack %b data %0d", a, d, 3'b001 << e.port, e.data); end
        n_checks++; if (rd_cnt != rd0) begin n_fail++; $display("FAIL oor_read_strobe: got %0d expected 0", rd_cnt - rd0); end
        release_all();
        wr0 = wr_cnt;
        drive_port(0, 1'b1, 0, H, 4'd5);
        sb.push_back('{0, 1'b0, 4'd0});
        wait_ack(10, lat, a, d);
        e = sb.pop_front();
        n_checks++; if (lat != 3 || a !== (3'b001 << e.port)) begin n_fail++; $display("FAIL oor_write_ack: got ack %b at %0d expected ack %b at 3", a, lat, 3'b001 << e.port); end
        n_checks++; if (wr_cnt != wr0) begin n_fail++; $display("FAIL oor_write_strobe: got %0d expected 0", wr_cnt - wr0); end
        release_all();
        rd0 = rd_cnt;
        drive_port(1, 1'b0, W-1, H-1, 4'd0);
        sb.push_back('{1, 1'b1, shadow[W-1][H-1]});
        wait_ack(10, lat, a, d);
        e = sb.pop_front();
        n_checks++; if (a !== (3'b001 << e.port) || d !== e.data || rd_cnt != rd0 + 1) begin n_fail++; $display("FAIL edge_read: got ack %b data %0d reads %0d expected ack %b data %0d reads 1", a, d, rd_cnt - rd0, 3'b001 << e.port, e.data); end
        release_all();
    endtask

    task automatic test_reset_mid;
        int lat;
        bit seen;
        logic [2:0] a;
        logic [3:0] d;
        exp_t e;
        do_reset();
        seen = 1'b0;
        drive_port(1, 1'b1, 7, 6, 4'd3);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mapa_write === 1'b1) begin seen = 1'b1; break; end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL midreset_strobe_seen: got 0 expected 1"); end
        reset = 1'b1;
        #1;
        n_checks++; if (mapa_write !== 1'b0) begin n_fail++; $display("FAIL midreset_write_drop: got %b expected 0", mapa_write); end
        n_checks++; if (ack !== 3'b000) begin n_fail++; $display("FAIL midreset_ack: got %b expected 000", ack); end
        @(posedge clk);
        #1;
        req   = '0;
        reset = 1'b0;
        sb.delete();
        wait_pronto();
        n_checks++; if (mem[7][6] !== shadow[7][6]) begin n_fail++; $display("FAIL midreset_lost_write: got %0d expected %0d", mem[7][6], shadow[7][6]); end
        drive_port(0, 1'b0, 2, 2, 4'd0);
        drive_port(1, 1'b0, 3, 3, 4'd0);
        sb.push_back('{0, 1'b1, shadow[2][2]});
        sb.push_back('{1, 1'b1, shadow[3][3]});
        for (int k = 0; k < 2; k++) begin
            wait_ack(12, lat, a, d);
            e = sb.pop_front();
            n_checks++; if (a !== (3'b001 << e.port) || d !== e.data) begin n_fail++; $display("FAIL midreset_order_%0d: got ack %b data %0d expected ack %b data %0d", k, a, d, 3'b001 << e.port, e.data); end
            if (k == 0) begin
                @(posedge clk);
                #1;
                req[0] = 1'b0;
            end
        end
        release_all();
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        we       = '0;
        req_x    = '0;
        req_y    = '0;
        req_dado = '0;
        for (int x = 0; x < 32; x++)
            for (int y = 0; y < 32; y++) begin
                mem[x][y]    = 4'(x ^ y);
                shadow[x][y] = 4'(x ^ y);
            end
        mem[5][5]    = 4'd9;
        shadow[5][5] = 4'd9;

        test_reset();
`ifdef MAPA_CLEAR_EN
        test_clear();
`endif
        test_preload();
        test_write_read();
        test_round_robin();
        test_out_of_range();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mapa_arbiter.md
# mapa_arbiter

Sequences all accesses to the single-port map RAM (`mapa`, 4-bit cell per (x,y)) and shares it round-robin between the snake update engine, the food spawner and the video renderer. Each requester issues a one-word read or write request and receives a one-cycle ack, with read data on reads. An optional post-reset sequencer clears the map before any requester is served. Sits between the game-logic blocks and the map RAM instance in the top level.

## Interface
- `MAPA_WIDTH`, 20, cells per row; legal x = 0..MAPA_WIDTH-1 (max 32)
- `MAPA_HEIGHT`, 15, rows; legal y = 0..MAPA_HEIGHT-1 (max 32)
- `NUM_REQ`, 3, requester count; port 0 = update, 1 = food, 2 = video
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high; one clock domain
- `req`  in  NUM_REQ  request per port, held until its ack
- `we`  in  NUM_REQ  1 = write, 0 = read; stable while req high
- `req_x`  in  5*NUM_REQ  x of port i at bits [5i+4:5i]
- `req_y`  in  5*NUM_REQ  y of port i, same packing
- `req_dado`  in  4*NUM_REQ  write data of port i at [4i+3:4i]
- `ack`  out  NUM_REQ  one-cycle pulse, port completed
- `rdata`  out  4  read data, valid only while some ack bit is high
- `pronto`  out  1  map usable; requests are served only while high
- `mapa_x`, `mapa_y`  out  5 each  RAM address
- `mapa_read`  out  1  RAM read strobe, data returned next cycle
- `mapa_write`  out  1  RAM write strobe
- `mapa_dado_write`  out  4  RAM write data
- `mapa_dado_read`  in  4  RAM read data, valid cycle after `mapa_read`

## Operation
- States: CLEAR (only with macro), IDLE, ACCESS, RESP.
- IDLE: if any `req` set, pick winner round-robin starting at (last_grant+1) mod NUM_REQ; latch winner index, we, x, y, data; go ACCESS. No req: stay.
- ACCESS: drive address/data and exactly one of `mapa_read`/`mapa_write` for one cycle; go RESP.
- RESP: capture `mapa_dado_read` into `rdata` (reads); pulse `ack[winner]`; update last_grant = winner; go IDLE.
- Out of range (x >= MAPA_WIDTH or y >= MAPA_HEIGHT): no strobe in ACCESS, write dropped, read returns 4'd0; ack still given at normal time.
- Requests arriving mid-transaction wait; req dropped before ack is a protocol violation (no ack required, latched access still completes to RAM).
- Port holding req high after ack re-enters arbitration in the following IDLE cycle, behind other pending ports.
- Reset values: all `ack` 0, `rdata` 0, `mapa_read`/`mapa_write` 0, `mapa_x`/`mapa_y`/`mapa_dado_write` 0, last_grant = NUM_REQ-1 (port 0 wins first), state CLEAR or IDLE.
- Reset mid-transaction: strobes drop immediately (async), no ack issued, pending access lost.

## Timing
- Request seen in IDLE on cycle N: strobe on N+1, `ack`/`rdata` on N+2, next grant decision N+3. Throughput one access per 3 cycles.
- Latency bound per port with all ports busy: 3*NUM_REQ cycles from request to ack.
- `mapa_*` outputs are registered; no combinational path from `req` to RAM pins.
- `pronto` registered; high in cycle after reset release when clear disabled.

## Configuration
- `MAPA_CLEAR_EN` defined: after reset, CLEAR writes 4'd0 (CELL_VAZIO) to every cell, row-major (y outer, x inner), one `mapa_write` per cycle, MAPA_WIDTH*MAPA_HEIGHT cycles; `pronto` low throughout, requests pending without ack; then IDLE, `pronto` high. Reset during CLEAR restarts from (0,0).
- Not defined: CLEAR state and counters absent; starts in IDLE, `pronto` high after reset; map contents are whatever the RAM holds.

## Structure
- `mapa_pkg`: COORD_W = 5, CELL_W = 4, CELL_VAZIO = 4'd0, state encoding constants.
- Sub-module `mapa_rr_pick`: combinational round-robin picker (req vector, last_grant) -> (valid, winner index); instantiated once.

## Test plan
- Port 0 writes (3,4)=4'd7, then reads (3,4) -> one write strobe at addr (3,4), then ack[0] with rdata 4'd7, 3 cycles per access.
- All three ports req from same cycle, held -> acks in order 0,1,2,0,… each 3 cycles apart; no port waits more than 9 cycles.
- Port 2 reads (20,0) with MAPA_WIDTH=20 -> no `mapa_read`, ack[2] at N+2, rdata 0; write to (0,15) -> no `mapa_write`, ack given.
- Reset asserted in ACCESS of a write -> `mapa_write` low immediately, no ack; after release port 0 served first.
- With `MAPA_CLEAR_EN`, 20x15 map: 300 writes of 0 covering (0,0)..(19,14), `pronto` rises after the last; req held during clear acked only after.
- Without `MAPA_CLEAR_EN`: `pronto` high first cycle after reset, read of preloaded cell (5,5)=4'd9 returns 4'd9.
